serial_rx: RTL and testbench



---
 rtl/serial_rx.sv | 191 +++++++++++++++++++
 tb/tb_serial_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// serial_rx: bit-serial frame receiver (start, WIDTH data LSB first, stop) with valid/ready output.
// Define SERIAL_RX_PARITY_EN to add a parity bit after the data (ODD selects odd parity).
module serial_rx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 16
`ifdef SERIAL_RX_PARITY_EN
  ,parameter bit         ODD   = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_s, r_s_d;
  logic [1:0]       r_prime;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [BW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_out;
  logic             r_valid, r_ferr, r_ovr;
  logic             w_cnt_zero, w_deliver, w_ferr, w_perr_hit, w_stop_perr, w_hs;
`ifdef SERIAL_RX_PARITY_EN
  logic             r_perr, w_perr_nxt, r_perr_pulse;
  assign w_stop_perr = r_perr;
`else
  assign w_stop_perr = 1'b0;
`endif

  assign w_cnt_zero = (r_cnt == '0);
  assign w_hs       = r_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_HIGH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    w_perr_hit  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    w_perr_nxt  = r_perr;
`endif
    case (r_state)
      // r_prime gates the exit until s reflects a real sample of the line, not the flop reset value
      WAIT_HIGH: if (r_prime[1] && r_s) w_state_nxt = IDLE;
      IDLE: begin
        if (r_s_d && !r_s) begin
          w_cnt_nxt   = HALF;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_cnt_zero) begin
          if (r_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = FULL;
            w_idx_nxt   = '0;
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_cnt_zero) begin
          w_shift_nxt = (r_shift >> 1) | (WIDTH'(r_s) << (WIDTH - 1));
          w_cnt_nxt   = FULL;
          if (r_idx == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            w_perr_nxt  = 1'b0;
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (w_cnt_zero) begin
          w_perr_nxt  = r_s ^ (^r_shift) ^ ODD;
          w_cnt_nxt   = FULL;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_cnt_zero) begin
          if (!r_s) begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end else if (w_stop_perr) begin
            w_perr_hit  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_deliver   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_s     <= 1'b1;
      r_s_d   <= 1'b1;
      r_prime <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
      r_prime <= {r_prime[0], 1'b1};
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_ferr  <= w_ferr;
      if (w_deliver) begin
        if (!r_valid || w_hs) begin
          r_out   <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr   <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr       <= 1'b0;
      r_perr_pulse <= 1'b0;
    end else begin
      r_perr       <= w_perr_nxt;
      r_perr_pulse <= w_perr_hit;
    end
  end
  assign parity_err = r_perr_pulse;
`else
  assign parity_err = w_perr_hit;
`endif

  assign out       = r_out;
  assign out_valid = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx (WIDTH=8, DIV=8); parity scenario built when SERIAL_RX_PARITY_EN is defined.
module tb_serial_rx;

  localparam int WIDTH = 8;
  localparam int DIV   = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  // start edge -> out_valid: 2 sync + DIV/2 + (bits after start)*DIV + 1
  localparam int LAT = 2 + DIV / 2 + (NBITS - 1) * DIV + 1;

  logic             clk;
  logic             rst_n;
  logic             in;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int ferr_cyc = 0;
  int perr_cyc = 0;
  int n_rise = 0;
  int n_valid_cyc = 0;
  int n_ferr = 0;
  int n_perr = 0;
  logic [WIDTH-1:0] rise_word = '0;
  logic prev_valid = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
  logic par_wrong = 1'b0;
`endif

`ifdef SERIAL_RX_PARITY_EN
  serial_rx #(.WIDTH(WIDTH), .DIV(DIV), .ODD(1'b0)) dut (
`else
  serial_rx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (out_valid) n_valid_cyc++;
    if (out_valid && !prev_valid) begin
      n_rise++;
      rise_cyc  = cyc;
      rise_word = out;
    end
    if (frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (parity_err) begin
      n_perr++;
      perr_cyc = cyc;
    end
    prev_valid = out_valid;
  end

  task automatic clear_mon();
    n_rise = 0; n_valid_cyc = 0; n_ferr = 0; n_perr = 0;
  endtask

  task automatic idle(input int n);
    in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; leaves the stop-bit level on the line
  task automatic drive_frame(input logic [WIDTH-1:0] data, input logic stop_bit);
    in = 1'b0;
    start_cyc = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < WIDTH; i++) begin
      in = data[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef SERIAL_RX_PARITY_EN
    in = (^data) ^ par_wrong;
    repeat (DIV) @(negedge clk);
`endif
    in = stop_bit;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    in = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out !== 8'h00)     begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    rst_n = 1'b1;
    clear_mon();
    repeat (40) @(negedge clk);
    checks++; if (n_rise != 0) begin errors++; $display("FAIL low_line_valid: got %0d expected 0", n_rise); end
    checks++; if (n_ferr != 0) begin errors++; $display("FAIL low_line_ferr: got %0d expected 0", n_ferr); end
    idle(20);
    checks++; if (n_rise != 0 || n_ferr != 0) begin errors++; $display("FAIL line_rise_quiet: got rise=%0d ferr=%0d expected 0 0", n_rise, n_ferr); end
    out_ready = 1'b1;
    drive_frame(8'h5A, 1'b1);
    idle(4);
    checks++; if (n_rise != 1 || rise_word !== 8'h5A) begin errors++; $display("FAIL first_frame: got n=%0d word=%h expected 1 5a", n_rise, rise_word); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    clear_mon();
    drive_frame(8'hA5, 1'b1);
    idle(4);
    checks++; if (rise_word !== 8'hA5 || n_rise != 1) begin errors++; $display("FAIL single_word: got n=%0d word=%h expected 1 a5", n_rise, rise_word); end
    checks++; if (rise_cyc - start_cyc != LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", rise_cyc - start_cyc, LAT); end
    checks++; if (n_valid_cyc != 1) begin errors++; $display("FAIL single_valid_len: got %0d expected 1", n_valid_cyc); end
    checks++; if (n_ferr != 0 || n_perr != 0 || overrun !== 1'b0) begin errors++; $display("FAIL single_errs: got ferr=%0d perr=%0d ovr=%b expected 0 0 0", n_ferr, n_perr, overrun); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    drive_frame(8'h3C, 1'b1);
    idle(3);
    checks++; if (out_valid !== 1'b1 || out !== 8'h3C) begin errors++; $display("FAIL ovr_first: got v=%b out=%h expected 1 3c", out_valid, out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", overrun); end
    drive_frame(8'h81, 1'b1);
    idle(3);
    checks++; if (out !== 8'h3C || out_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold: got v=%b out=%h expected 1 3c", out_valid, out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    @(negedge clk);
  endtask

  task automatic test_glitch();
    out_ready = 1'b1;
    clear_mon();
    in = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    checks++; if (n_rise != 0 || n_ferr != 0 || n_perr != 0) begin errors++; $display("FAIL glitch_quiet: got rise=%0d ferr=%0d perr=%0d expected 0 0 0", n_rise, n_ferr, n_perr); end
    drive_frame(8'h55, 1'b1);
    idle(4);
    checks++; if (n_rise != 1 || rise_word !== 8'h55) begin errors++; $display("FAIL glitch_next: got n=%0d word=%h expected 1 55", n_rise, rise_word); end
  endtask

  task automatic test_frame_err();
    out_ready = 1'b1;
    clear_mon();
    drive_frame(8'hFF, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (n_ferr != 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", n_ferr); end
    checks++; if (ferr_cyc - start_cyc != LAT) begin errors++; $display("FAIL ferr_time: got %0d expected %0d", ferr_cyc - start_cyc, LAT); end
    checks++; if (n_rise != 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", n_rise); end
    idle(10);
    checks++; if (n_rise != 0 || n_ferr != 1) begin errors++; $display("FAIL ferr_release: got rise=%0d ferr=%0d expected 0 1", n_rise, n_ferr); end
    drive_frame(8'h12, 1'b1);
    idle(4);
    checks++; if (n_rise != 1 || rise_word !== 8'h12) begin errors++; $display("FAIL ferr_recover: got n=%0d word=%h expected 1 12", n_rise, rise_word); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    drive_frame(8'h11, 1'b1);
    idle(3);
    checks++; if (out_valid !== 1'b1 || out !== 8'h11) begin errors++; $display("FAIL b2b_first: got v=%b out=%h expected 1 11", out_valid, out); end
    fork
      drive_frame(8'h22, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out !== 8'h22 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_swap: got v=%b out=%h expected 1 22", out_valid, out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr: got %b expected 0", overrun); end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    idle(3);
    checks++; if (out !== 8'h22 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold: got v=%b out=%h expected 1 22", out_valid, out); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    clear_mon();
    fork
      drive_frame(8'hA5, 1'b1);
      begin
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_clear: got v=%b out=%h expected 0 00", out_valid, out); end
      end
    join
    idle(5);
    rst_n = 1'b1;
    idle(30);
    checks++; if (n_rise != 0 || n_ferr != 0) begin errors++; $display("FAIL midrst_no_deliver: got rise=%0d ferr=%0d expected 0 0", n_rise, n_ferr); end
    drive_frame(8'hC3, 1'b1);
    idle(4);
    checks++; if (n_rise != 1 || rise_word !== 8'hC3) begin errors++; $display("FAIL midrst_next: got n=%0d word=%h expected 1 c3", n_rise, rise_word); end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    clear_mon();
    par_wrong = 1'b1;
    drive_frame(8'h07, 1'b1);
    idle(4);
    par_wrong = 1'b0;
    checks++; if (n_perr != 1) begin errors++; $display("FAIL parity_pulse: got %0d cycles expected 1", n_perr); end
    checks++; if (perr_cyc - start_cyc != LAT) begin errors++; $display("FAIL parity_time: got %0d expected %0d", perr_cyc - start_cyc, LAT); end
    checks++; if (n_rise != 0 || n_ferr != 0) begin errors++; $display("FAIL parity_discard: got rise=%0d ferr=%0d expected 0 0", n_rise, n_ferr); end
    clear_mon();
    drive_frame(8'h07, 1'b1);
    idle(4);
    checks++; if (n_rise != 1 || rise_word !== 8'h07 || n_perr != 0) begin errors++; $display("FAIL parity_good: got n=%0d word=%h perr=%0d expected 1 07 0", n_rise, rise_word, n_perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
